// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request, data_memory and response signals of mem_access_ctrl
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [RD_W-1:0]   req_rd;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_data_in;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [RD_W-1:0]   resp_rd;
    logic              misalign_err;
    logic              busy;

    modport slave (
        input  req_valid, req_is_store, req_addr, req_wdata, req_rd, mem_data_in, resp_ready,
        output req_ready, mem_address, mem_read_en, mem_write_en, mem_write_data,
               resp_valid, resp_data, resp_rd, misalign_err, busy
    );

    modport master (
        output req_valid, req_is_store, req_addr, req_wdata, req_rd, mem_data_in, resp_ready,
        input  req_ready, mem_address, mem_read_en, mem_write_en, mem_write_data,
               resp_valid, resp_data, resp_rd, misalign_err, busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store access controller in front of data_memory
module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int RD_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [RD_W-1:0]   rd_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [RD_W-1:0]   resp_rd_q;
    logic              misalign_q;

    // Enables come straight from the registered state so they fall with an async reset.
    assign bus.req_ready      = (state == IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.mem_read_en    = (state == READ);
    assign bus.mem_write_en   = (state == WRITE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_rd        = resp_rd_q;
    assign bus.misalign_err   = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        // Misaligned requests are dropped without touching the memory.
                        if (bus.req_addr[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end else begin
                            addr_q  <= bus.req_addr;
                            wdata_q <= bus.req_wdata;
                            rd_q    <= bus.req_rd;
                            cnt     <= '0;
                            state   <= bus.req_is_store ? WRITE : READ;
                        end
                    end
                end
                WRITE: state <= IDLE;
                READ: begin
                    if (cnt == CNT_LAST) begin
                        resp_data_q <= bus.mem_data_in;
                        resp_rd_q   <= rd_q;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store access controller between the execute stage and the data_memory block. It accepts one load or store request at a time over a valid/ready handshake, checks word alignment, and drives data_memory's address, read/write enables and write data. For loads it waits a configurable read latency, captures the read word and returns it with its destination register id over a valid/ready response channel.

Parameters:
ADDR_W, 32, byte address width driven to data_memory
DATA_W, 32, data word width
READ_LAT, 1, clock cycles from mem_read_en assertion until mem_data_in is valid (0 = combinational read)
RD_W, 5, destination register id width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_is_store  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
req_rd  in  RD_W  load destination register id
mem_address  out  ADDR_W  to data_memory address
mem_read_en  out  1  to data_memory memRead_enable
mem_write_en  out  1  to data_memory memWrite_enable
mem_write_data  out  DATA_W  to data_memory write_data
mem_data_in  in  DATA_W  from data_memory data_out
resp_valid  out  1  load result valid
resp_ready  in  1  consumer accepts load result
resp_data  out  DATA_W  load result
resp_rd  out  RD_W  destination register id of result
misalign_err  out  1  one-cycle pulse: request dropped for misalignment
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, latch registers 0, counter 0; mem_address=0, mem_read_en=0, mem_write_en=0, mem_write_data=0, resp_valid=0, resp_data=0, resp_rd=0, misalign_err=0, busy=0. req_ready=1 while in IDLE.
- States: IDLE, WRITE, READ, RESP.
- req_ready = (state==IDLE). Handshake fires on the rising edge where req_valid && req_ready; req_addr/req_wdata/req_rd/req_is_store latched at that edge.
- Alignment: req_addr[1:0] != 0 on a fired handshake -> no memory access, stay IDLE, misalign_err=1 for exactly the next cycle; request discarded, no response.
- Store (aligned): IDLE -> WRITE. WRITE lasts exactly 1 cycle: mem_write_en=1, mem_address=latched addr, mem_write_data=latched data; then -> IDLE. No response generated. A new request can be accepted 2 cycles after the previous one.
- Load (aligned): IDLE -> READ. READ lasts READ_LAT+1 cycles: mem_read_en=1 and mem_address held stable throughout. mem_data_in is sampled into resp_data on the edge that ends the final READ cycle; resp_rd <= latched rd; -> RESP.
- RESP: resp_valid=1, resp_data/resp_rd held stable until resp_valid && resp_ready on an edge; then -> IDLE with resp_valid=0. req_ready=0 throughout RESP (no overlap of requests with a pending response).
- mem_read_en and mem_write_en are decoded from the registered state only; never both 1; both 0 in IDLE and RESP. mem_address/mem_write_data retain last latched values outside WRITE/READ.
- Counter: counts 0..READ_LAT in READ, cleared on entry; READ_LAT=0 gives a 1-cycle READ.
- Reset mid-operation: any state aborts immediately to IDLE; enables drop asynchronously; pending load response is lost.
- req_valid held high across cycles is a new request each time req_ready is high (back-to-back requests allowed).

Test Plan:
- Store addr 0x0000_0010 data 0xDEAD_BEEF -> one cycle later mem_write_en=1 for exactly 1 cycle with address 0x10, data 0xDEADBEEF; req_ready back to 1 the cycle after.
- Load addr 0x10, rd=7, READ_LAT=1, memory model returns 0xDEADBEEF -> mem_read_en high 2 cycles, resp_valid=1 with resp_data=0xDEADBEEF, resp_rd=7, 3 cycles after handshake.
- Load with resp_ready=0 for 4 cycles -> resp_valid, resp_data, resp_rd stable for all 4 cycles, req_ready=0; release -> IDLE next cycle.
- Load addr 0x0000_0013 -> misalign_err pulse 1 cycle, mem_read_en never asserted, no resp_valid, req_ready stays 1.
- Repeat load with READ_LAT=0 and READ_LAT=3 -> READ state lasts 1 and 4 cycles respectively; correct word captured.
- Assert rst during READ -> mem_read_en drops in same cycle, resp_valid stays 0, all outputs at reset values; next load completes normally.
